// File: rtl/axi_uart_tx_wrapper_pkg.sv
// Shared constants for the AXI-Lite UART/MIDI transmit wrapper: response codes,
// register offsets and the transmitter state encoding.
package axi_uart_tx_wrapper_pkg;

  localparam logic [1:0] C_OKAY    = 2'b00;
  localparam logic [1:0] C_EX_OKAY = 2'b01;
  localparam logic [1:0] C_SLV_ERR = 2'b10;
  localparam logic [1:0] C_DEC_ERR = 2'b11;

  localparam logic [31:0] C_REG_TXDATA = 32'h0;
  localparam logic [31:0] C_REG_STATUS = 32'h4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/axi_uart_tx_wrapper_if.sv
// AXI4-Lite bus bundle for the transmit wrapper; the slave modport is the wrapper's view.
interface axi_uart_tx_wrapper_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 4
);
  logic [C_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [C_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_uart_tx_wrapper_uart_tx.sv
// Byte serialiser: start bit, 8 data bits (LSB or MSB first), stop bit, each CLKS_PER_BIT cycles.
module uart_tx
  import axi_uart_tx_wrapper_pkg::*;
#(
  parameter int LSB_FIRST    = 1,
  parameter int CLKS_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_vld,
  output logic       o_rdy,
  output logic       o_data,
  output logic       done_flg
);
  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    o_data   = 1'b1;
    o_rdy    = 1'b0;
    done_flg = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_rdy = 1'b1;
        if (i_vld) w_next = S_START;
      end
      S_START: begin
        o_data = 1'b0;
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        o_data = (LSB_FIRST != 0) ? r_shreg[0] : r_shreg[7];
        if (w_bit_end && r_bit == 3'd7) w_next = S_STOP;
      end
      S_STOP: begin
        done_flg = w_bit_end;
        if (w_bit_end) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bit-period counter idles at zero so each START begins a fresh full period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      if (r_state == S_IDLE || w_bit_end) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;
      if (r_state == S_IDLE)                   r_bit <= '0;
      else if (r_state == S_DATA && w_bit_end) r_bit <= r_bit + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && i_vld)
      r_shreg <= i_data;
    else if (r_state == S_DATA && w_bit_end)
      r_shreg <= (LSB_FIRST != 0) ? {1'b0, r_shreg[7:1]} : {r_shreg[6:0], 1'b0};
  end

endmodule

// File: rtl/axi_uart_tx_wrapper.sv
// AXI4-Lite slave feeding a small TX FIFO that drains into uart_tx; STATUS readable at 0x4.
module axi_uart_tx_wrapper
  import axi_uart_tx_wrapper_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_ADDR_WIDTH   = 4,
  parameter int C_LSB_FIRST    = 1,
  parameter int C_CLKS_PER_BIT = 3200,
  parameter int C_FIFO_DEPTH   = 4
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  axi_uart_tx_wrapper_if.slave  s_axi,
  output logic                  midi_out,
  output logic                  midi_intr
);
  localparam int PW = $clog2(C_FIFO_DEPTH);

  logic [7:0]              r_mem [C_FIFO_DEPTH];
  logic [PW-1:0]           r_wptr, r_rptr;
  logic [PW:0]             r_level;
  logic                    r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]              r_bresp, r_rresp;
  logic [C_DATA_WIDTH-1:0] r_rdata;

  logic                    w_full, w_empty, w_push, w_pop, w_tx_rdy;
  logic                    w_wr_txdata, w_rd_txdata, w_rd_status;
  logic [1:0]              w_bresp, w_rresp;
  logic [C_DATA_WIDTH-1:0] w_status, w_rdata;
  logic                    w_unused;

  assign w_full      = (r_level == (PW+1)'(C_FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_wr_txdata = (s_axi.awaddr[C_ADDR_WIDTH-1:2] == C_REG_TXDATA[C_ADDR_WIDTH-1:2]);
  assign w_rd_txdata = (s_axi.araddr[C_ADDR_WIDTH-1:2] == C_REG_TXDATA[C_ADDR_WIDTH-1:2]);
  assign w_rd_status = (s_axi.araddr[C_ADDR_WIDTH-1:2] == C_REG_STATUS[C_ADDR_WIDTH-1:2]);

  // Fullness is judged before any same-cycle pop, so a full FIFO always rejects
  assign w_push  = r_awready & w_wr_txdata & s_axi.wstrb[0] & ~w_full;
  assign w_pop   = ~w_empty & w_tx_rdy;
  assign w_bresp = (w_wr_txdata && !(s_axi.wstrb[0] && w_full)) ? C_OKAY : C_SLV_ERR;

  always_comb begin
    w_status              = '0;
    w_status[0]           = ~w_tx_rdy;
    w_status[1]           = w_full;
    w_status[2]           = w_empty;
    w_status[4 +: PW + 1] = r_level;
  end

  assign w_rdata = w_rd_status ? w_status : '0;
  assign w_rresp = (w_rd_status || w_rd_txdata) ? C_OKAY : C_SLV_ERR;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= C_OKAY;
    end else begin
      r_awready <= s_axi.awvalid & s_axi.wvalid & ~r_bvalid & ~r_awready;
      if (r_awready) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_bresp;
      end else if (s_axi.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= C_OKAY;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_axi.arvalid & ~r_arready & ~r_rvalid;
      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_rresp;
        r_rdata  <= w_rdata;
      end else if (r_rvalid && s_axi.rready) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (w_push) r_mem[r_wptr] <= s_axi.wdata[7:0];
  end

  uart_tx #(
    .LSB_FIRST    (C_LSB_FIRST),
    .CLKS_PER_BIT (C_CLKS_PER_BIT)
  ) u_uart_tx (
    .clk      (s_axi_aclk),
    .rst      (s_axi_areset),
    .i_data   (r_mem[r_rptr]),
    .i_vld    (~w_empty),
    .o_rdy    (w_tx_rdy),
    .o_data   (midi_out),
    .done_flg (midi_intr)
  );

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_awready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = r_rdata;

  assign w_unused = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0],
                      s_axi.wdata[C_DATA_WIDTH-1:8], s_axi.wstrb[C_DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_axi_uart_tx_wrapper.sv
// Randomised scoreboard bench: a frame-schedule model predicts responses, STATUS and the serial line.
module tb_axi_uart_tx_wrapper;
  import axi_uart_tx_wrapper_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  axi_uart_tx_wrapper_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(4)) ifa ();
  axi_uart_tx_wrapper_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(4)) ifb ();

  logic mo_a, mi_a, mo_b, mi_b;

  axi_uart_tx_wrapper #(
    .C_DATA_WIDTH(32), .C_ADDR_WIDTH(4), .C_LSB_FIRST(1),
    .C_CLKS_PER_BIT(CPB), .C_FIFO_DEPTH(DEPTH)
  ) dut_a (
    .s_axi_aclk(clk), .s_axi_areset(rst), .s_axi(ifa), .midi_out(mo_a), .midi_intr(mi_a)
  );

  // MSB-first twin sees the identical bus stream, so only its bit order differs
  axi_uart_tx_wrapper #(
    .C_DATA_WIDTH(32), .C_ADDR_WIDTH(4), .C_LSB_FIRST(0),
    .C_CLKS_PER_BIT(CPB), .C_FIFO_DEPTH(DEPTH)
  ) dut_b (
    .s_axi_aclk(clk), .s_axi_areset(rst), .s_axi(ifb), .midi_out(mo_b), .midi_intr(mi_b)
  );

  assign ifb.awaddr  = ifa.awaddr;
  assign ifb.awprot  = ifa.awprot;
  assign ifb.awvalid = ifa.awvalid;
  assign ifb.wdata   = ifa.wdata;
  assign ifb.wstrb   = ifa.wstrb;
  assign ifb.wvalid  = ifa.wvalid;
  assign ifb.bready  = ifa.bready;
  assign ifb.araddr  = ifa.araddr;
  assign ifb.arprot  = ifa.arprot;
  assign ifb.arvalid = ifa.arvalid;
  assign ifb.rready  = ifa.rready;

  // Reference model: accepted bytes with their push cycle and scheduled start-bit cycle
  int          acc_push[$];
  int          acc_start[$];
  int          fr_s[$];
  logic [7:0]  fr_b[$];
  int          last_s = -1000;
  logic [1:0]  q_bresp[$];
  logic [1:0]  q_rresp[$];
  logic [31:0] q_rdata[$];

  function automatic string resp_name(input logic [1:0] r);
    case (r)
      C_OKAY:    return "OKAY";
      C_EX_OKAY: return "EXOKAY";
      C_SLV_ERR: return "SLVERR";
      C_DEC_ERR: return "DECERR";
      default:   return "X";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: bound expired", name, cyc);
  endtask

  // Bytes held in the FIFO during cycle m: pushed before m, not yet popped (pop = start - 1)
  function automatic int model_level(input int m);
    int n = 0;
    foreach (acc_push[i]) if (acc_push[i] < m && acc_start[i] - 1 >= m) n++;
    return n;
  endfunction

  function automatic logic model_busy(input int m);
    foreach (acc_start[i]) if (m >= acc_start[i] && m < acc_start[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(input int n, input logic [3:0] addr, input logic [7:0] d,
                             input logic strb0, output logic [1:0] resp);
    int s;
    resp = C_SLV_ERR;
    if (addr == 4'h0) begin
      resp = C_OKAY;
      if (strb0) begin
        if (model_level(n) >= DEPTH) begin
          resp = C_SLV_ERR;
        end else begin
          s = (n + 2 > last_s + FRAME + 1) ? n + 2 : last_s + FRAME + 1;
          acc_push.push_back(n);
          acc_start.push_back(s);
          fr_s.push_back(s);
          fr_b.push_back(d);
          last_s = s;
        end
      end
    end
  endtask

  task automatic model_read(input int m, input logic [3:0] addr,
                            output logic [31:0] d, output logic [1:0] resp);
    int lvl;
    d    = 32'h0;
    resp = C_OKAY;
    if (addr == 4'h4) begin
      lvl = model_level(m);
      d = (32'(lvl) << 4) | (32'(lvl == 0) << 2) | (32'(lvl == DEPTH) << 1) | 32'(model_busy(m));
    end else if (addr != 4'h0) begin
      resp = C_SLV_ERR;
    end
  endtask

  task automatic model_clear();
    acc_push.delete();
    acc_start.delete();
    fr_s.delete();
    fr_b.delete();
    q_bresp.delete();
    q_rresp.delete();
    q_rdata.delete();
    last_s = -1000;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int t = 0;
    logic [1:0] er;
    ifa.awaddr  = addr;
    ifa.wdata   = data;
    ifa.wstrb   = strb;
    ifa.awvalid = 1'b1;
    ifa.wvalid  = 1'b1;
    do begin @(negedge clk); t++; end while (!ifa.awready && t < 50);
    if (ifa.awready) begin
      model_write(cyc, addr, data[7:0], strb[0], er);
      q_bresp.push_back(er);
    end else begin
      fail_now("aw_handshake");
    end
    @(negedge clk);
    ifa.awvalid = 1'b0;
    ifa.wvalid  = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr);
    int t = 0;
    logic [31:0] d;
    logic [1:0]  r;
    ifa.araddr  = addr;
    ifa.arvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!ifa.arready && t < 50);
    if (ifa.arready) begin
      model_read(cyc, addr, d, r);
      q_rdata.push_back(d);
      q_rresp.push_back(r);
    end else begin
      fail_now("ar_handshake");
    end
    @(negedge clk);
    ifa.arvalid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((fr_s.size() != 0 || q_bresp.size() != 0 || q_rresp.size() != 0) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) fail_now("drain");
  endtask

  // Ready randomiser: changes just after the posedge so a whole cycle sees one value
  initial begin
    ifa.bready = 1'b1;
    ifa.rready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ifa.bready = ($urandom_range(0, 3) != 0);
      ifa.rready = ($urandom_range(0, 3) != 0);
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (ifa.bvalid && ifa.bready) begin
      if (q_bresp.size() == 0) begin
        checks++; errors++;
        $display("FAIL bresp_unexpected at cycle %0d: got %s, expected no response", cyc, resp_name(ifa.bresp));
      end else begin
        check("bresp", ifa.bresp, q_bresp.pop_front());
      end
    end
    if (ifa.rvalid && ifa.rready) begin
      if (q_rresp.size() == 0) begin
        checks++; errors++;
        $display("FAIL rresp_unexpected at cycle %0d: got %s, expected no response", cyc, resp_name(ifa.rresp));
      end else begin
        check("rresp", ifa.rresp, q_rresp.pop_front());
        check("rdata", ifa.rdata, q_rdata.pop_front());
      end
    end
  end

  // Serial-line monitor for both bit orders plus interrupt pulses
  always @(negedge clk) begin : line_mon
    int   m, k;
    logic exp_a, exp_b, exp_i;
    m = cyc;
    while (fr_s.size() != 0 && m >= fr_s[0] + FRAME) begin
      void'(fr_s.pop_front());
      void'(fr_b.pop_front());
    end
    exp_a = 1'b1;
    exp_b = 1'b1;
    exp_i = 1'b0;
    if (fr_s.size() != 0 && m >= fr_s[0]) begin
      k = (m - fr_s[0]) / CPB;
      if (k == 0) begin
        exp_a = 1'b0;
        exp_b = 1'b0;
      end else if (k <= 8) begin
        exp_a = fr_b[0][k-1];
        exp_b = fr_b[0][8-k];
      end
      exp_i = (m == fr_s[0] + FRAME - 1);
    end
    check("midi_out_lsb", mo_a, exp_a);
    check("midi_out_msb", mo_b, exp_b);
    check("midi_intr_lsb", mi_a, exp_i);
    check("midi_intr_msb", mi_b, exp_i);
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: bench did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] addrs [6];
    int         r;
    addrs[0] = 4'h0; addrs[1] = 4'h0; addrs[2] = 4'h0;
    addrs[3] = 4'h4; addrs[4] = 4'h8; addrs[5] = 4'hC;

    ifa.awaddr = '0; ifa.awprot = 3'b0; ifa.awvalid = 1'b0;
    ifa.wdata  = '0; ifa.wstrb  = '0;   ifa.wvalid  = 1'b0;
    ifa.araddr = '0; ifa.arprot = 3'b0; ifa.arvalid = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_awready", ifa.awready, 0);
    check("rst_wready",  ifa.wready,  0);
    check("rst_bvalid",  ifa.bvalid,  0);
    check("rst_arready", ifa.arready, 0);
    check("rst_rvalid",  ifa.rvalid,  0);
    check("rst_bresp",   ifa.bresp,   0);
    check("rst_rresp",   ifa.rresp,   0);
    check("rst_rdata",   ifa.rdata,   0);
    axi_read(4'h4);
    drain(100);

    // Single byte, then the MSB-first probe byte
    axi_write(4'h0, 32'h0000_00A5, 4'hF);
    drain(100);
    axi_write(4'h0, 32'h0000_0001, 4'hF);
    drain(100);

    // Overflow burst with a STATUS snapshot while the FIFO is full
    for (int i = 0; i < 6; i++) axi_write(4'h0, 32'h11 + i, 4'hF);
    axi_read(4'h4);
    drain(400);

    // Address and strobe errors
    axi_write(4'h4, 32'h0000_0055, 4'hF);
    axi_write(4'h8, 32'h0000_0066, 4'hF);
    axi_write(4'hC, 32'h0000_0077, 4'hF);
    axi_read(4'hC);
    axi_read(4'h8);
    axi_read(4'h0);
    axi_write(4'h0, 32'h0000_00F0, 4'hE);
    axi_read(4'h4);
    drain(100);

    // Randomised traffic
    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r < 6) axi_write(addrs[$urandom_range(0, 5)], $urandom, 4'($urandom_range(0, 15)) | 4'(r < 4));
      else       axi_read(addrs[$urandom_range(0, 5)]);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    drain(1000);

    // Reset in the middle of a frame with bytes still queued
    axi_write(4'h0, 32'h0000_003C, 4'hF);
    axi_write(4'h0, 32'h0000_00C3, 4'hF);
    axi_write(4'h0, 32'h0000_005A, 4'hF);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    model_clear();
    #1;
    check("rstmid_midi_out_lsb", mo_a, 1);
    check("rstmid_midi_out_msb", mo_b, 1);
    check("rstmid_midi_intr", mi_a, 0);
    check("rstmid_bvalid", ifa.bvalid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    axi_read(4'h4);
    repeat (100) @(negedge clk);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
